control_display_7seg: RTL



---
 rtl/control_display_7seg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/control_display_7seg.sv
// control_display_7seg
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Holds a shadow copy of four BCD digits and decimal points, walks
// the digit slots at a fixed rate, blanks the start of every slot to avoid
// ghosting and optionally suppresses leading zeros. All outputs are
// registered, so they follow the scan state with one cycle of latency.
module control_display_7seg #(
  parameter int DIV_CICLOS   = 100000,
  parameter int BLANK_CICLOS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] datos,
  input  logic [3:0]  puntos,
  input  logic        cargar,
  input  logic        supr_ceros,
  input  logic        habilitar,
  output logic [3:0]  bcd,
  output logic [3:0]  anodo,
  output logic        dp,
  output logic [1:0]  digito_act
);

  localparam int CW = (DIV_CICLOS > 1) ? $clog2(DIV_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV_CICLOS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CICLOS);

  // Extract one 4-bit digit from the packed shadow word.
  function automatic logic [3:0] pick_digit(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = word[3:0];
      2'd1:    r = word[7:4];
      2'd2:    r = word[11:8];
      2'd3:    r = word[15:12];
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  logic [15:0]   reg_datos_q, reg_datos_d;
  logic [3:0]    reg_pto_q,   reg_pto_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [1:0]    dig_q,       dig_d;
  logic [3:0]    anodo_q,     anodo_d;
  logic [3:0]    bcd_q,       bcd_d;
  logic          dp_q,        dp_d;
  logic [1:0]    digito_act_q, digito_act_d;

  logic [3:0] es_cero_s;
  logic [3:0] suprimido_s;
  logic       visible_s;
  logic [3:0] digito_s;

  // Shadow register load and slot/digit scan sequencing.
  always_comb begin
    reg_datos_d = reg_datos_q;
    reg_pto_d   = reg_pto_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    if (cargar) begin
      reg_datos_d = datos;
      reg_pto_d   = puntos;
    end else begin
      reg_datos_d = reg_datos_q;
      reg_pto_d   = reg_pto_q;
    end
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      dig_d = dig_q;
    end
  end

  // Leading-zero suppression chain: a digit is dark only if it and every
  // digit to its left are zero. Digit 0 always shows, so "0" is never blank.
  always_comb begin
    es_cero_s[0] = (reg_datos_q[3:0]   == 4'h0);
    es_cero_s[1] = (reg_datos_q[7:4]   == 4'h0);
    es_cero_s[2] = (reg_datos_q[11:8]  == 4'h0);
    es_cero_s[3] = (reg_datos_q[15:12] == 4'h0);
    suprimido_s[3] = supr_ceros & es_cero_s[3];
    suprimido_s[2] = suprimido_s[3] & es_cero_s[2];
    suprimido_s[1] = suprimido_s[2] & es_cero_s[1];
    suprimido_s[0] = 1'b0;
  end

  // Next output values: light the current slot only past the blanking window.
  always_comb begin
    digito_s     = pick_digit(reg_datos_q, dig_q);
    visible_s    = habilitar & (cnt_q >= BLANK_END) & ~suprimido_s[dig_q];
    digito_act_d = dig_q;
    if (visible_s) begin
      anodo_d = ~(4'b0001 << dig_q);
      bcd_d   = digito_s;
      dp_d    = ~reg_pto_q[dig_q];
    end else begin
      anodo_d = 4'b1111;
      bcd_d   = 4'hF;
      dp_d    = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_datos_q  <= 16'h0000;
      reg_pto_q    <= 4'b0000;
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      anodo_q      <= 4'b1111;
      bcd_q        <= 4'hF;
      dp_q         <= 1'b1;
      digito_act_q <= 2'd0;
    end else begin
      reg_datos_q  <= reg_datos_d;
      reg_pto_q    <= reg_pto_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      anodo_q      <= anodo_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      digito_act_q <= digito_act_d;
    end
  end

  assign anodo      = anodo_q;
  assign bcd        = bcd_q;
  assign dp         = dp_q;
  assign digito_act = digito_act_q;

endmodule
